wb_poll_master: RTL and testbench

Command-driven Wishbone classic initiator: drives single read/write cycles and polled reads toward slaves such as the GPIO peripheral. A local controller hands it one command at a time over a valid/ready port and receives one response per command, including timeout and poll-exhaustion status. It sits between a local sequencer (boot/init logic, debug bridge) and the Wishbone interconnect.

---
 rtl/wb_master_pkg.sv | 29 ++
 rtl/wb_poll_master.sv | 200 ++++++++++++++++++++
 tb/tb_wb_poll_master.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_master_pkg.sv
// Shared types for the polling Wishbone initiator: command op codes,
// response status codes, FSM states and default bus widths.
package wb_master_pkg;

  localparam int DEFAULT_ADR_WIDTH = 32;
  localparam int DEFAULT_DAT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_WRITE   = 2'b00,
    OP_READ    = 2'b01,
    OP_POLL    = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_OK        = 2'b00,
    ST_TIMEOUT   = 2'b01,
    ST_EXHAUSTED = 2'b10,
    ST_ILLEGAL   = 2'b11
  } status_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    GAP  = 2'b10,
    RESP = 2'b11
  } state_e;

endpackage

// File: rtl/wb_poll_master.sv
// Command-driven Wishbone classic initiator issuing single writes, reads and
// polled reads, returning one response (data + status) per accepted command.
module wb_poll_master
  import wb_master_pkg::*;
#(
  parameter int WB_ADR_WIDTH = DEFAULT_ADR_WIDTH,
  parameter int WB_DAT_WIDTH = DEFAULT_DAT_WIDTH,
  parameter int ACK_TIMEOUT  = 255,
  parameter int POLL_MAX     = 1023,
  parameter int POLL_GAP     = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_valid_i,
  output logic                      cmd_ready_o,
  input  logic [1:0]                cmd_op_i,
  input  logic [WB_ADR_WIDTH-1:0]   cmd_adr_i,
  input  logic [WB_DAT_WIDTH-1:0]   cmd_dat_i,
  input  logic [WB_DAT_WIDTH-1:0]   cmd_mask_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [WB_DAT_WIDTH-1:0]   rsp_dat_o,
  output logic [1:0]                rsp_status_o,
  output logic [WB_ADR_WIDTH-1:0]   wb_adr_o,
  output logic [WB_DAT_WIDTH-1:0]   wb_dat_o,
  output logic                      wb_we_o,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  output logic [WB_DAT_WIDTH/8-1:0] wb_sel_o,
  input  logic                      wb_ack_i,
  input  logic [WB_DAT_WIDTH-1:0]   wb_dat_i
);

  // One counter serves both the ack timeout (BUS) and the inter-poll gap (GAP).
  localparam int CNT_MAX = (ACK_TIMEOUT > POLL_GAP) ? ACK_TIMEOUT : POLL_GAP;
  localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
  localparam int TW      = (POLL_MAX < 2) ? 1 : $clog2(POLL_MAX + 1);

  state_e                  state, state_n;
  logic [CW-1:0]           cnt, cnt_n;
  logic [TW-1:0]           tries, tries_n;
  op_e                     op_q, op_n;
  logic [WB_DAT_WIDTH-1:0] dat_q, dat_n;
  logic [WB_DAT_WIDTH-1:0] mask_q, mask_n;
  logic                    cyc_q, cyc_n;
  logic                    we_q, we_n;
  logic [WB_ADR_WIDTH-1:0] adr_q, adr_n;
  logic [WB_DAT_WIDTH-1:0] wdat_q, wdat_n;
  logic                    rsp_valid_q, rsp_valid_n;
  logic [WB_DAT_WIDTH-1:0] rsp_dat_q, rsp_dat_n;
  status_e                 rsp_status_q, rsp_status_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      tries        <= '0;
      op_q         <= OP_WRITE;
      dat_q        <= '0;
      mask_q       <= '0;
      cyc_q        <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= '0;
      wdat_q       <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_dat_q    <= '0;
      rsp_status_q <= ST_OK;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      tries        <= tries_n;
      op_q         <= op_n;
      dat_q        <= dat_n;
      mask_q       <= mask_n;
      cyc_q        <= cyc_n;
      we_q         <= we_n;
      adr_q        <= adr_n;
      wdat_q       <= wdat_n;
      rsp_valid_q  <= rsp_valid_n;
      rsp_dat_q    <= rsp_dat_n;
      rsp_status_q <= rsp_status_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    tries_n      = tries;
    op_n         = op_q;
    dat_n        = dat_q;
    mask_n       = mask_q;
    cyc_n        = cyc_q;
    we_n         = we_q;
    adr_n        = adr_q;
    wdat_n       = wdat_q;
    rsp_valid_n  = rsp_valid_q;
    rsp_dat_n    = rsp_dat_q;
    rsp_status_n = rsp_status_q;

    unique case (state)
      IDLE: begin
        if (cmd_valid_i) begin
          op_n   = op_e'(cmd_op_i);
          dat_n  = cmd_dat_i;
          mask_n = cmd_mask_i;
          if (op_e'(cmd_op_i) == OP_ILLEGAL) begin
            state_n      = RESP;
            rsp_valid_n  = 1'b1;
            rsp_status_n = ST_ILLEGAL;
            rsp_dat_n    = '0;
          end else begin
            state_n = BUS;
            cnt_n   = '0;
            tries_n = TW'(1);
            cyc_n   = 1'b1;
            we_n    = (op_e'(cmd_op_i) == OP_WRITE);
            adr_n   = cmd_adr_i;
            wdat_n  = (op_e'(cmd_op_i) == OP_WRITE) ? cmd_dat_i : '0;
          end
        end
      end

      BUS: begin
        // An ack on the final timeout cycle still completes the transfer.
        if (wb_ack_i) begin
          cnt_n  = '0;
          cyc_n  = 1'b0;
          we_n   = 1'b0;
          wdat_n = '0;
          if (op_q != OP_POLL) begin
            state_n      = RESP;
            rsp_valid_n  = 1'b1;
            rsp_status_n = ST_OK;
            rsp_dat_n    = (op_q == OP_READ) ? wb_dat_i : '0;
          end else if (((wb_dat_i ^ dat_q) & mask_q) == '0) begin
            state_n      = RESP;
            rsp_valid_n  = 1'b1;
            rsp_status_n = ST_OK;
            rsp_dat_n    = wb_dat_i;
          end else if (tries == TW'(POLL_MAX)) begin
            state_n      = RESP;
            rsp_valid_n  = 1'b1;
            rsp_status_n = ST_EXHAUSTED;
            rsp_dat_n    = wb_dat_i;
          end else begin
            tries_n = tries + 1'b1;
            if (POLL_GAP == 0) begin
              state_n = BUS;
              cyc_n   = 1'b1;
            end else begin
              state_n = GAP;
            end
          end
        end else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
          state_n      = RESP;
          cnt_n        = '0;
          cyc_n        = 1'b0;
          we_n         = 1'b0;
          wdat_n       = '0;
          rsp_valid_n  = 1'b1;
          rsp_status_n = ST_TIMEOUT;
          rsp_dat_n    = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      GAP: begin
        if (cnt == CW'(POLL_GAP - 1)) begin
          state_n = BUS;
          cnt_n   = '0;
          cyc_n   = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      RESP: begin
        if (rsp_ready_i) begin
          state_n     = IDLE;
          rsp_valid_n = 1'b0;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  assign cmd_ready_o  = (state == IDLE) && !rst;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_dat_o    = rsp_dat_q;
  assign rsp_status_o = rsp_status_q;
  assign wb_adr_o     = adr_q;
  assign wb_dat_o     = wdat_q;
  assign wb_we_o      = we_q;
  assign wb_cyc_o     = cyc_q;
  assign wb_stb_o     = cyc_q;
  assign wb_sel_o     = '1;

endmodule

// File: tb/tb_wb_poll_master.sv
// Randomized self-checking bench for wb_poll_master with a behavioural slave
// and a transaction-level reference model of the expected response.
module tb_wb_poll_master;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int AT = 8;
  localparam int PM = 5;
  localparam int PG = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid_i, cmd_ready_o;
  logic [1:0]    cmd_op_i;
  logic [AW-1:0] cmd_adr_i;
  logic [DW-1:0] cmd_dat_i, cmd_mask_i;
  logic          rsp_valid_o, rsp_ready_i;
  logic [DW-1:0] rsp_dat_o;
  logic [1:0]    rsp_status_o;
  logic [AW-1:0] wb_adr_o;
  logic [DW-1:0] wb_dat_o;
  logic          wb_we_o, wb_cyc_o, wb_stb_o;
  logic [DW/8-1:0] wb_sel_o;
  logic          wb_ack_i;
  logic [DW-1:0] wb_dat_i;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wb_poll_master #(
    .WB_ADR_WIDTH(AW), .WB_DAT_WIDTH(DW),
    .ACK_TIMEOUT(AT), .POLL_MAX(PM), .POLL_GAP(PG)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_adr_i(cmd_adr_i),
    .cmd_dat_i(cmd_dat_i), .cmd_mask_i(cmd_mask_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_dat_o(rsp_dat_o), .rsp_status_o(rsp_status_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_sel_o(wb_sel_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i)
  );

  // Behavioural slave: ack after slave_wait stalled cycles, reads served from rd_values in order.
  int          slave_wait  = 0;
  bit          slave_noack = 1'b0;
  logic [31:0] rd_values [8];
  int          rd_count = 0;
  int          rd_start = 0;
  int          wcnt     = 0;
  int          rd_idx;

  assign rd_idx   = rd_count - rd_start;
  assign wb_ack_i = wb_cyc_o & wb_stb_o & ~slave_noack & (wcnt >= slave_wait);
  assign wb_dat_i = (rd_idx >= 0 && rd_idx < 8) ? rd_values[rd_idx[2:0]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (wb_cyc_o && wb_stb_o && !wb_ack_i) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (wb_cyc_o && wb_stb_o && wb_ack_i && !wb_we_o) rd_count <= rd_count + 1;
  end

  // Bus observations gathered once per negedge while a command is in flight.
  int          acks, stb_cycles, we_cycles, gaps, gap_bad, rdat_bad, sel_bad, idle_run;
  bit          had_bus;
  logic [31:0] last_adr, last_wdat;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_bus_stats();
    acks = 0; stb_cycles = 0; we_cycles = 0; gaps = 0; gap_bad = 0;
    rdat_bad = 0; sel_bad = 0; idle_run = 0; had_bus = 1'b0;
    last_adr = '0; last_wdat = '0;
  endtask

  task automatic sample_bus();
    if (wb_cyc_o && wb_stb_o) begin
      stb_cycles++;
      last_adr = wb_adr_o;
      if (wb_sel_o != 4'hF) sel_bad++;
      if (wb_we_o) begin
        we_cycles++;
        last_wdat = wb_dat_o;
      end else if (wb_dat_o != '0) begin
        rdat_bad++;
      end
      if (wb_ack_i) acks++;
      if (had_bus && idle_run > 0) begin
        gaps++;
        if (idle_run != PG) gap_bad++;
      end
      idle_run = 0;
      had_bus  = 1'b1;
    end else if (had_bus) begin
      idle_run++;
    end
  endtask

  // Reference model: outcome of one command from the slave setup alone.
  task automatic model(input logic [1:0] op, input logic [31:0] dat, input logic [31:0] mask,
                       input int wt, input bit noack,
                       output logic [1:0] e_status, output logic [31:0] e_dat,
                       output int e_acks, output int e_stb, output int e_lat);
    int n;
    bit found;
    if (op == 2'b11) begin
      e_status = 2'b11; e_dat = 0; e_acks = 0; e_stb = 0; e_lat = 1;
    end else if (noack) begin
      e_status = 2'b01; e_dat = 0; e_acks = 0; e_stb = AT; e_lat = AT + 1;
    end else if (op == 2'b00 || op == 2'b01) begin
      e_status = 2'b00; e_dat = (op == 2'b01) ? rd_values[0] : 32'h0;
      e_acks = 1; e_stb = wt + 1; e_lat = wt + 2;
    end else begin
      n = 0; found = 1'b0;
      for (int i = 0; i < PM; i++) begin
        n = i + 1;
        if ((rd_values[i] & mask) == (dat & mask)) begin
          found = 1'b1;
          break;
        end
      end
      e_status = found ? 2'b00 : 2'b10;
      e_dat    = rd_values[n-1];
      e_acks   = n;
      e_stb    = n * (wt + 1);
      e_lat    = n * (wt + 1) + (n - 1) * PG + 1;
    end
  endtask

  task automatic applyStimulus(input logic [1:0] op, input logic [31:0] adr, input logic [31:0] dat,
                               input logic [31:0] mask, input int wt, input bit noack, input int hold);
    logic [1:0]  e_status;
    logic [31:0] e_dat, h_dat;
    logic [1:0]  h_status;
    int          e_acks, e_stb, e_lat, lat, hold_bad;
    bit          accepted, seen;
    model(op, dat, mask, wt, noack, e_status, e_dat, e_acks, e_stb, e_lat);

    @(negedge clk);
    slave_wait  = wt;
    slave_noack = noack;
    rd_start    = rd_count;
    clear_bus_stats();
    cmd_valid_i = 1'b1;
    cmd_op_i    = op;
    cmd_adr_i   = adr;
    cmd_dat_i   = dat;
    cmd_mask_i  = mask;
    accepted    = 1'b0;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(posedge clk);
      if (cmd_ready_o) accepted = 1'b1;
    end
    #1 cmd_valid_i = 1'b0;
    checkOutput("accept", accepted, 1);
    if (!accepted) return;

    seen = 1'b0;
    lat  = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      lat++;
      sample_bus();
      if (rsp_valid_o) seen = 1'b1;
    end
    checkOutput("rsp_seen", seen, 1);
    checkOutput("latency", lat, e_lat);
    checkOutput("status", rsp_status_o, e_status);
    checkOutput("rsp_dat", rsp_dat_o, e_dat);
    checkOutput("acks", acks, e_acks);
    checkOutput("stb_cycles", stb_cycles, e_stb);
    checkOutput("sel", sel_bad, 0);
    if (op == 2'b00) begin
      checkOutput("we_cycles", we_cycles, e_stb);
      checkOutput("wdat", last_wdat, dat);
    end else begin
      checkOutput("we_cycles", we_cycles, 0);
      checkOutput("rd_wdat_zero", rdat_bad, 0);
    end
    if (e_stb > 0) checkOutput("adr", last_adr, adr);
    if (op == 2'b10 && !noack) begin
      checkOutput("gaps", gaps, e_acks - 1);
      checkOutput("gap_len", gap_bad, 0);
    end

    h_dat    = rsp_dat_o;
    h_status = rsp_status_o;
    hold_bad = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (!rsp_valid_o || cmd_ready_o || wb_cyc_o || rsp_dat_o != h_dat || rsp_status_o != h_status)
        hold_bad++;
    end
    if (hold > 0) checkOutput("hold_stable", hold_bad, 0);

    rsp_ready_i = 1'b1;
    @(negedge clk);
    rsp_ready_i = 1'b0;
    checkOutput("rsp_drop", rsp_valid_o, 0);
    checkOutput("ready_back", cmd_ready_o, 1);
    slave_noack = 1'b0;
  endtask

  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_dat, r_mask;
    rst = 1'b1;
    cmd_valid_i = 1'b0; cmd_op_i = '0; cmd_adr_i = '0; cmd_dat_i = '0; cmd_mask_i = '0;
    rsp_ready_i = 1'b0;
    for (int i = 0; i < 8; i++) rd_values[i] = '0;

    repeat (3) @(negedge clk);
    checkOutput("rst_cmd_ready", cmd_ready_o, 0);
    checkOutput("rst_cyc", {wb_cyc_o, wb_stb_o, wb_we_o}, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_ready", cmd_ready_o, 1);
    checkOutput("post_rst_rsp", {rsp_valid_o, rsp_status_o, rsp_dat_o}, 0);
    checkOutput("post_rst_bus", {wb_adr_o, wb_dat_o}, 0);

    $display("[TB] directed commands");
    applyStimulus(2'b00, 32'h04, 32'hA5, 32'h0, 1, 1'b0, 0);
    rd_values[0] = 32'h5A;
    applyStimulus(2'b01, 32'h00, 32'h0, 32'h0, 0, 1'b0, 0);
    rd_values[0] = 32'h10; rd_values[1] = 32'h20; rd_values[2] = 32'h31; rd_values[3] = 32'h41;
    applyStimulus(2'b10, 32'h00, 32'h1, 32'h1, 1, 1'b0, 0);
    for (int i = 0; i < 8; i++) rd_values[i] = 32'h100 + 2 * i;
    applyStimulus(2'b10, 32'h00, 32'h1, 32'h1, 0, 1'b0, 0);
    applyStimulus(2'b01, 32'h08, 32'h0, 32'h0, 0, 1'b1, 0);
    applyStimulus(2'b00, 32'h0C, 32'h1234_5678, 32'h0, 2, 1'b0, 0);
    applyStimulus(2'b11, 32'h10, 32'hFFFF, 32'h0, 0, 1'b0, 10);

    // Reset asserted while a stalled read is on the bus.
    @(negedge clk);
    slave_noack = 1'b1;
    cmd_valid_i = 1'b1; cmd_op_i = 2'b01; cmd_adr_i = 32'h20;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("pre_rst_cyc", wb_cyc_o, 1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_rst_bus", {wb_cyc_o, wb_stb_o}, 0);
    checkOutput("mid_rst_rsp", rsp_valid_o, 0);
    checkOutput("mid_rst_ready", cmd_ready_o, 0);
    rst = 1'b0;
    slave_noack = 1'b0;
    @(negedge clk);
    checkOutput("after_rst_ready", cmd_ready_o, 1);
    rd_values[0] = 32'hCAFE_0001;
    applyStimulus(2'b01, 32'h24, 32'h0, 32'h0, 1, 1'b0, 0);

    $display("[TB] random commands");
    for (int n = 0; n < 40; n++) begin
      r_op   = 2'($urandom_range(0, 3));
      r_dat  = $urandom;
      r_mask = ($urandom_range(0, 3) == 0) ? $urandom : (32'h1 << $urandom_range(0, 31));
      for (int i = 0; i < 8; i++) begin
        rd_values[i] = $urandom;
        if ($urandom_range(0, 9) < 3) rd_values[i] = (r_dat & r_mask) | (rd_values[i] & ~r_mask);
      end
      applyStimulus(r_op, $urandom & 32'hFFFF_FFFC, r_dat, r_mask,
                    $urandom_range(0, 2), ($urandom_range(0, 9) == 0), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
